event_counter_bank: RTL
=======================

Name: event_counter_bank

Overview:
- Multi-channel, parametrised event counter bank that generalises the team's single N-bit counter.
- Adds per-channel variable increment, saturate-or-wrap mode, sticky overflow flags, per-channel clear, and a global atomic snapshot with optional clear-on-snapshot.
- Sits behind the PRBS checkers and accumulates per-lane bit-error and word counts for readout without losing events.

Parameters:
- NUM_CH, 4, number of independent counter channels (1..16)
- WIDTH, 32, counter width in bits per channel (2..48)
- INC_W, 8, width of the per-channel increment value; INC_W <= WIDTH
- INIT, 0, value loaded into counters on reset and clear; must be < 2^WIDTH
- SATURATE, 1, 1 = clamp at 2^WIDTH-1; 0 = wrap modulo 2^WIDTH
- CLR_ON_SNAP, 1, 1 = the snapshot also clears counters and overflow flags

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  NUM_CH  per-channel increment enable
- inc_val  in  NUM_CH*INC_W  per-channel increment amount; channel i occupies bits [i*INC_W +: INC_W]
- clear  in  NUM_CH  per-channel clear request
- snap  in  1  global snapshot request, level-sampled each cycle
- count  out  NUM_CH*WIDTH  live registered counts
- ovf  out  NUM_CH  per-channel sticky overflow flags
- snap_count  out  NUM_CH*WIDTH  captured counts
- snap_ovf  out  NUM_CH  captured overflow flags
- snap_valid  out  1  one-cycle pulse when snap_count/snap_ovf update
- any_ovf  out  1  OR of ovf

Behaviour:
- Reset: count=INIT and ovf=0 on all channels; snap_count=0, snap_ovf=0, snap_valid=0. Reset overrides all other inputs in the same cycle, including snap.
- Per channel i, per cycle:
  - eff_inc = enable[i] ? inc_val[i] : 0
  - clr_i = clear[i] | (snap & CLR_ON_SNAP)
  - base = clr_i ? INIT : count[i]
  - sum = base + eff_inc, computed at WIDTH+1 bits
- Overflow: carry = sum[WIDTH].
  - SATURATE=1: next = carry ? all-ones : sum[WIDTH-1:0]. Once at all-ones, the counter holds until clear or reset.
  - SATURATE=0: next = sum[WIDTH-1:0].
- Increments are never lost on a clear: a clear in the same cycle as an enable yields INIT+inc_val, not INIT.
- ovf[i] next = carry | (ovf[i] & ~clr_i). A carry in the same cycle as a clear sets ovf; set wins.
- Latency: count and ovf reflect enable/clear sampled at edge N from edge N onward, i.e. one cycle after input.
- Snapshot:
  - When snap=1 at edge N, snap_count/snap_ovf load the pre-update count/ovf values from the cycle of the request.
  - snap_valid=1 for exactly the cycle after edge N.
  - The same-cycle increment is not in the snapshot. With CLR_ON_SNAP=1 it goes into the post-clear counter, so snapshot + residual equals the true total.
- Back-to-back snap (held high): snap_valid stays high; each cycle captures the preceding cycle's counts.
- CLR_ON_SNAP=0: snap has no effect on count or ovf.
- snap_count/snap_ovf hold between snapshots. There is no ready/ack; a consumer must sample on snap_valid.
- Channels are fully independent apart from the shared snap.
- No combinational path from inputs to outputs except any_ovf, which derives from registered ovf only.

Test Plan (WIDTH=8, INC_W=4, NUM_CH=2, INIT=0 unless stated):
- Reset then enable[0]=1, inc_val=3 for 5 cycles -> count0 = 3,6,9,12,15, one per cycle; count1=0; ovf=0.
- SATURATE=1, count0=250, inc 7 -> count0=255, ovf[0]=1, any_ovf=1. Further incs hold 255. clear[0] with inc 2 in the same cycle -> count0=2, ovf[0]=0.
- SATURATE=0, count0=250, inc 7 -> count0=1, ovf[0]=1. Next clear with no inc -> count0=0, ovf[0]=0.
- CLR_ON_SNAP=1, count0=40, count1=9, snap=1 with enable[0] inc 5 in the same cycle -> next cycle snap_count={9,40}, snap_valid=1 for one cycle, count0=5, count1=0.
- CLR_ON_SNAP=0, snap held 3 cycles while inc 1 each cycle from count0=10 -> snap_count0 = 10,11,12; snap_valid high 3 cycles; count0 not cleared.
- Assert reset while snap=1 and enable=1, INIT=7 -> count=7 on all channels, ovf=0, snap_valid=0, snap_count=0.

Source files
------------

// File: rtl/event_counter_bank.sv
// ---------------------------------------------------------------------------
// event_counter_bank : multi-channel event counters with variable increment,
//                      saturate/wrap, sticky overflow and atomic snapshot.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module event_counter_bank #(
  parameter int          NUM_CH      = 4,
  parameter int          WIDTH       = 32,
  parameter int          INC_W       = 8,
  parameter logic [63:0] INIT        = 64'd0,
  parameter int          SATURATE    = 1,
  parameter int          CLR_ON_SNAP = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*INC_W-1:0] inc_val,
  input  logic [NUM_CH-1:0]       clear,
  input  logic                    snap,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH*WIDTH-1:0] snap_count,
  output logic [NUM_CH-1:0]       snap_ovf,
  output logic                    snap_valid,
  output logic                    any_ovf
);

  localparam logic [WIDTH-1:0] c_init      = INIT[WIDTH-1:0];
  localparam logic             c_saturate  = (SATURATE != 0);
  localparam logic             c_snap_clr  = (CLR_ON_SNAP != 0);
  localparam int               c_pad_w     = WIDTH + 1 - INC_W;

  logic w_snap_clr;
  assign w_snap_clr = snap & c_snap_clr;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i = i + 1) begin : g_ch
      logic [WIDTH-1:0] r_cnt;
      logic             r_ovf;
      logic             w_clr;
      logic [INC_W-1:0] w_inc;
      logic [WIDTH-1:0] w_base;
      logic [WIDTH:0]   w_sum;
      logic             w_carry;
      logic [WIDTH-1:0] w_cnt_nxt;
      logic             w_ovf_nxt;

      always_comb begin
        w_clr     = clear[i] | w_snap_clr;
        w_inc     = enable[i] ? inc_val[i*INC_W +: INC_W] : '0;
        // Clear replaces the base, not the increment, so no event is dropped.
        w_base    = w_clr ? c_init : r_cnt;
        w_sum     = {1'b0, w_base} + {{c_pad_w{1'b0}}, w_inc};
        w_carry   = w_sum[WIDTH];
        w_cnt_nxt = (c_saturate && w_carry) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        w_ovf_nxt = w_carry | (r_ovf & ~w_clr);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= c_init;
          r_ovf <= 1'b0;
        end else begin
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
        end
      end

      assign count[i*WIDTH +: WIDTH] = r_cnt;
      assign ovf[i]                  = r_ovf;
    end
  endgenerate

  // Snapshot takes the pre-update registered values, so the same-cycle
  // increment lands in the (possibly cleared) live counter instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_count <= '0;
      snap_ovf   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) begin
        snap_count <= count;
        snap_ovf   <= ovf;
      end
    end
  end

  assign any_ovf = |ovf;

endmodule

`default_nettype wire
